// File: rtl/line_memory_pkg.sv
// line_memory_pkg: shared state encoding, geometry helpers and default sizes for line_memory.
package line_memory_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int DEF_LINE_BITS = 128;
    localparam int DEF_DEPTH     = 4096;
    localparam int DEF_LATENCY   = 19;

    function automatic int ofs_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/line_memory_array.sv
// line_memory_array: single-port synchronous line RAM with byte-enabled writes.
// The read register is resettable so the top can expose it directly as data_from_mem.
module line_memory_array #(
    parameter int LINE_BITS = 128,
    parameter int DEPTH     = 4096,
    parameter int IDX       = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   re,
    input  logic                   we,
    input  logic [IDX-1:0]         addr,
    input  logic [LINE_BITS-1:0]   wdata,
    input  logic [LINE_BITS/8-1:0] wmask,
    output logic [LINE_BITS-1:0]   rdata
);
    logic [LINE_BITS-1:0] ram [DEPTH];

    always_ff @(posedge clk)
        if (we)
            for (int b = 0; b < LINE_BITS / 8; b++)
                if (wmask[b])
                    ram[addr][b*8 +: 8] <= wdata[b*8 +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= ram[addr];

endmodule

// File: rtl/line_memory.sv
// line_memory: whole-line memory with a cycle-counted latency FSM and busy/ready handshake.
// Define LINE_MEMORY_WMASK_EN to add the wmask byte-enable port for writes.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int ADDR_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   read,
    input  logic                   write,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [LINE_BITS-1:0]   data_to_mem,
`ifdef LINE_MEMORY_WMASK_EN
    input  logic [LINE_BITS/8-1:0] wmask,
`endif
    output logic                   busy,
    output logic                   ready,
    output logic [LINE_BITS-1:0]   data_from_mem
);
    localparam int OFS = ofs_bits(LINE_BITS);
    localparam int IDX = idx_bits(DEPTH);
    localparam int NB  = LINE_BITS / 8;
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IDX-1:0]       idx, ram_addr;
    logic                 op_read;
    logic [LINE_BITS-1:0] wdata;
    logic [NB-1:0]        mask;
    logic                 req, ram_re, ram_we, unused_addr;

    assign req         = read | write;
    assign unused_addr = ^addr;
    assign ram_addr    = (state == IDLE) ? addr[OFS+IDX-1:OFS] : idx;
    // The read lands on the edge entering DONE; with LATENCY==1 that is the accepting edge itself.
    assign ram_re      = (state == IDLE) ? (LATENCY == 1) && read
                                         : (state == WAIT) && op_read && (cnt == CW'(1));
    assign ram_we      = (state == DONE) && !op_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            op_read <= 1'b0;
            wdata   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state   <= (LATENCY == 1) ? DONE : WAIT;
                    cnt     <= CW'(LATENCY - 1);
                    idx     <= addr[OFS+IDX-1:OFS];
                    op_read <= read;
                    wdata   <= data_to_mem;
                    busy    <= 1'b1;
                    ready   <= (LATENCY == 1);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef LINE_MEMORY_WMASK_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            mask <= '0;
        else if (state == IDLE && req)
            mask <= wmask;
`else
    assign mask = '1;
`endif

    line_memory_array #(
        .LINE_BITS(LINE_BITS),
        .DEPTH    (DEPTH),
        .IDX      (IDX)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .re   (ram_re),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata),
        .wmask(mask),
        .rdata(data_from_mem)
    );

endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: directed test of line_memory against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_line_memory;
    localparam int LAT = 19;
    typedef logic [127:0] line_t;

    localparam line_t L_DB = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
    localparam line_t L_P  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam line_t L_Q  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam line_t L_A  = 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555;
    localparam line_t L_B  = 128'h5A5A_5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA;
    localparam line_t L_X  = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;

    logic        clk = 0, rst_n = 1, en = 0;
    logic        read = 0, write = 0;
    logic [31:0] addr = 0;
    line_t       din = 0;
    logic [15:0] wm = '1;
    logic        busy, ready;
    line_t       dout;

    logic        r1 = 0, w1 = 0;
    logic [31:0] a1 = 0;
    line_t       d1 = 0;
    logic        b1, rd1;
    line_t       q1;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    line_memory #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_to_mem(din),
`ifdef LINE_MEMORY_WMASK_EN
        .wmask(wm),
`endif
        .busy(busy), .ready(ready), .data_from_mem(dout)
    );

    line_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .read(r1), .write(w1), .addr(a1), .data_to_mem(d1),
`ifdef LINE_MEMORY_WMASK_EN
        .wmask(16'hFFFF),
`endif
        .busy(b1), .ready(rd1), .data_from_mem(q1)
    );

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: one transaction at a time, described by its start edge and completion edge.
    line_t       mem [int];
    int          e = 0, t_end = 0, t_idx = 0;
    bit          act = 0, t_rd = 0;
    line_t       t_dat = 0, exp_dout = 0;
    logic [15:0] t_m = '1;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % 4096);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        line_t tmp;
        if (!rst_n) begin
            act      = 0;
            exp_dout = '0;
        end else begin
            e++;
            if (act && e == t_end + 1) begin
                if (!t_rd) begin
                    tmp = mem.exists(t_idx) ? mem[t_idx] : '0;
                    for (int b = 0; b < 16; b++)
                        if (t_m[b]) tmp[b*8 +: 8] = t_dat[b*8 +: 8];
                    mem[t_idx] = tmp;
                end
                act = 0;
            end else if (!act && (read || write)) begin
                act   = 1;
                t_rd  = read;
                t_idx = line_of(addr);
                t_dat = din;
                t_m   = wm;
                t_end = e + LAT - 1;
            end
            if (act && t_rd && e == t_end)
                exp_dout = mem.exists(t_idx) ? mem[t_idx] : '0;
        end
    end

    always @(negedge clk) if (en) begin
        chk("busy", line_t'(busy), line_t'(act));
        chk("ready", line_t'(ready), line_t'(act && e == t_end));
        chk("data_from_mem", dout, exp_dout);
    end

    // Issue one request from IDLE, wait for ready, then step past DONE.
    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input line_t d,
                      input logic [15:0] m, output int n);
        read = rd; write = wr; addr = a; din = d; wm = m;
        @(posedge clk); #1;
        read = 0; write = 0; wm = '1;
        n = 1;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst_n = 0;
        en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_busy", line_t'(busy), '0);
        chk("reset_ready", line_t'(ready), '0);
        chk("reset_dout", dout, '0);
        chk("reset_busy1", line_t'(b1), '0);
        chk("reset_dout1", q1, '0);

        op(0, 1, 32'h0000_0040, L_DB, '1, n);
        chk("wr_latency", line_t'(n), line_t'(19));
        chk("busy_after_wr_ready", line_t'(busy), '0);
        op(1, 0, 32'h0000_0040, '0, '1, n);
        chk("rd_latency", line_t'(n), line_t'(19));
        chk("rd_data", dout, L_DB);
        chk("busy_after_rd_ready", line_t'(busy), '0);
        op(1, 0, 32'h0000_004C, '0, '1, n);
        chk("offset_ignored", dout, L_DB);

        op(0, 1, 32'h0000_0100, L_P, '1, n);
        op(1, 1, 32'h0000_0100, L_Q, '1, n);
        chk("rw_read_priority", dout, L_P);
        op(1, 0, 32'h0000_0100, '0, '1, n);
        chk("rw_no_write", dout, L_P);

        read = 1; addr = 32'h0000_0040;
        @(posedge clk); #1;
        read = 0;
        repeat (4) begin @(posedge clk); #1; end
        write = 1; din = L_Q;
        @(posedge clk); #1;
        write = 0;
        n = 0;
        repeat (2 * LAT) begin
            if (ready) n++;
            @(posedge clk); #1;
        end
        chk("wait_pulse_count", line_t'(n), line_t'(1));
        op(1, 0, 32'h0000_0040, '0, '1, n);
        chk("wait_no_extra_write", dout, L_DB);

        op(0, 1, 32'h0000_0200, L_A, '1, n);
        write = 1; addr = 32'h0000_0200; din = L_B;
        @(posedge clk); #1;
        write = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_busy", line_t'(busy), '0);
        chk("abort_ready", line_t'(ready), '0);
        chk("abort_dout", dout, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1;
        op(1, 0, 32'h0000_0200, '0, '1, n);
        chk("abort_old_line", dout, L_A);

        w1 = 1; a1 = 32'h0000_FFF0; d1 = L_X;
        @(posedge clk); #1;
        w1 = 0;
        chk("lat1_wr_ready", line_t'(rd1), line_t'(1));
        @(posedge clk); #1;
        chk("lat1_ready_drop", line_t'(rd1), '0);
        chk("lat1_busy_drop", line_t'(b1), '0);
        r1 = 1; a1 = 32'hFFFF_FFF0;
        @(posedge clk); #1;
        r1 = 0;
        chk("lat1_rd_ready", line_t'(rd1), line_t'(1));
        chk("lat1_alias_data", q1, L_X);

`ifdef LINE_MEMORY_WMASK_EN
        op(0, 1, 32'h0000_0300, '0, 16'hFFFF, n);
        op(0, 1, 32'h0000_0300, '1, 16'h000F, n);
        op(1, 0, 32'h0000_0300, '0, '1, n);
        chk("wmask_low_word", dout, 128'hFFFF_FFFF);
        op(0, 1, 32'h0000_0300, L_Q, 16'h0000, n);
        chk("wmask_zero_ready", line_t'(n), line_t'(19));
        op(1, 0, 32'h0000_0300, '0, '1, n);
        chk("wmask_zero_unchanged", dout, 128'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
